rlbp_wb_host: RTL

RLBP_WB_HOST -- requirements
Module: rlbp_wb_host

---
 rtl/rlbp_wb_host.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/rlbp_wb_host.sv
// rlbp_wb_host: byte-stream command bridge to a single Wishbone master port.
//
// The external host sends commands as bytes on a valid/ready stream:
//   0x01 = write: 4 address bytes, then 4 data bytes (LSB first)
//   0x02 = read:  4 address bytes (LSB first)
// Any other opcode is answered with the status byte 0xFF, and no bus cycle
// is issued. Each command produces one Wishbone cycle. A per-cycle wait
// counter aborts the cycle after TIMEOUT_CYCLES cycles without an ack.
// Responses are returned on a second valid/ready stream. The status byte
// comes first: 0x00 = OK, 0xEE = timeout, 0xFF = bad opcode. A successful
// read then sends 4 data bytes, LSB first.
//
// Ports:
//   wb_clk_i, wb_rst_ni            clock, async active-low reset
//   cmd_data_i/valid_i/ready_o     command byte stream (in)
//   rsp_data_o/valid_o/ready_i     response byte stream (out)
//   wbm_*                          Wishbone master (sel is fixed at 4'hF)
//   busy_o                         high whenever the FSM is not idle
//   err_o                          sticky timeout flag, cleared by next valid opcode
module rlbp_wb_host #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [7:0]  cmd_data_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RSP} state_t;

    // Last counter value before the timeout fires; the cycle in which the
    // counter would reach TIMEOUT_CYCLES is the final cycle with cyc high.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  rsp_left_q, rsp_left_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic cmd_fire;
    logic rsp_fire;

    assign cmd_fire = cmd_valid_i & cmd_ready_q;
    assign rsp_fire = rsp_valid_q & rsp_ready_i;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cyc_d       = cyc_q;
        rd_data_d   = rd_data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_left_d  = rsp_left_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_data_i == 8'h01 || cmd_data_i == 8'h02) begin
                        we_d       = (cmd_data_i == 8'h01);
                        err_d      = 1'b0;
                        byte_cnt_d = 2'd0;
                        state_d    = S_ADDR;
                    end else begin
                        rsp_data_d  = 8'hFF;
                        rsp_valid_d = 1'b1;
                        rsp_left_d  = 3'd0;
                        state_d     = S_RSP;
                    end
                end
            end
            S_ADDR: begin
                if (cmd_fire) begin
                    // LSB-first: each new byte enters at the top and shifts down.
                    adr_d      = {cmd_data_i, adr_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d    = S_BUS;
                            cyc_d      = 1'b1;
                            wait_cnt_d = 16'd0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (cmd_fire) begin
                    dat_d      = {cmd_data_i, dat_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = S_BUS;
                        cyc_d      = 1'b1;
                        wait_cnt_d = 16'd0;
                    end
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rd_data_d   = wbm_dat_i;
                    rsp_data_d  = 8'h00;
                    rsp_valid_d = 1'b1;
                    rsp_left_d  = we_q ? 3'd0 : 3'd4;
                    state_d     = S_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_q == TO_LAST) begin
                        cyc_d       = 1'b0;
                        err_d       = 1'b1;
                        rsp_data_d  = 8'hEE;
                        rsp_valid_d = 1'b1;
                        rsp_left_d  = 3'd0;
                        state_d     = S_RSP;
                    end
                end
            end
            S_RSP: begin
                if (rsp_fire) begin
                    if (rsp_left_q == 3'd0) begin
                        rsp_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        rsp_data_d = rd_data_q[7:0];
                        rd_data_d  = {8'h00, rd_data_q[31:8]};
                        rsp_left_d = rsp_left_q - 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            cyc_q       <= 1'b0;
            rd_data_q   <= 32'd0;
            rsp_data_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_left_q  <= 3'd0;
            wait_cnt_q  <= 16'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            rd_data_q   <= rd_data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_left_q  <= rsp_left_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = 4'hF;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
